// File: rtl/booth_sched.sv
// Two-requester round-robin front end for a shared multi-cycle Booth multiplier core.
// One request in flight at a time; a watchdog aborts a hung core with rsp_err.
module booth_sched #(
  parameter int WIDTH   = 192,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [2*WIDTH-1:0]   rsp_c,
  output logic                 rsp_err,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_c,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t     state, state_next;
  logic       owner;      // requester whose operands are in flight
  logic       prio;       // requester that wins a tie
  logic [7:0] wdog;
  logic       grant0, grant1;
  logic       accept0, accept1;
  logic       rsp_take;
  logic       timed_out;

  assign grant0 = req0_valid & (~req1_valid | ~prio);
  assign grant1 = req1_valid & (~req0_valid | prio);

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;

  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;
  assign rsp_take   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  assign mul_start  = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign timed_out  = (wdog == 8'(TIMEOUT));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept0 | accept1) state_next = ISSUE;
      ISSUE:   state_next = BUSY;
      BUSY:    if (mul_done | timed_out) state_next = RESP;
      RESP:    if (rsp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      prio    <= 1'b0;
      wdog    <= 8'd0;
      mul_a   <= '0;
      mul_b   <= '0;
      rsp_c   <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept0) begin
            owner <= 1'b0;
            prio  <= 1'b1;
            mul_a <= req0_a;
            mul_b <= req0_b;
          end else if (accept1) begin
            owner <= 1'b1;
            prio  <= 1'b0;
            mul_a <= req1_a;
            mul_b <= req1_b;
          end
        end
        ISSUE: wdog <= 8'd1;
        BUSY: begin
          // a completion in the same cycle as the timeout still wins
          if (mul_done) begin
            rsp_c   <= mul_c;
            rsp_err <= 1'b0;
          end else if (timed_out) begin
            rsp_c   <= '0;
            rsp_err <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_sched.md
BOOTH_SCHED -- requirements
Module: booth_sched

Interface
REQ-001 Parameter: WIDTH, 192, operand width in bits; product width is 2*WIDTH.
REQ-002 Parameter: TIMEOUT, 255, maximum BUSY cycles before abort; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req0_valid / req1_valid  input  1  requester n has an operand pair pending.
REQ-006 Port: req0_ready / req1_ready  output  1  requester n's operands accepted this cycle.
REQ-007 Port: req0_a, req0_b / req1_a, req1_b  input  WIDTH  two's-complement operands of requester n.
REQ-008 Port: rsp0_valid / rsp1_valid  output  1  result for requester n is present.
REQ-009 Port: rsp0_ready / rsp1_ready  input  1  requester n consumes its result.
REQ-010 Port: rsp_c  output  2*WIDTH  product, shared by both response channels.
REQ-011 Port: rsp_err  output  1  qualifies rsp_c; 1 = timed out, rsp_c is all zeros.
REQ-012 Port: mul_start  output  1  one-cycle start pulse to the shared Booth core.
REQ-013 Port: mul_a, mul_b  output  WIDTH  operands to the core.
REQ-014 Port: mul_done  input  1  core result valid, single-cycle pulse.
REQ-015 Port: mul_c  input  2*WIDTH  core product, sampled only when mul_done=1.
REQ-016 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, BUSY, RESP; a single request is in flight at any time.
REQ-018 In IDLE, reqN_ready is driven combinationally high only for the arbitration winner, and only when at least one reqN_valid is high.
REQ-019 Arbitration is round-robin: a single valid requester wins, and with both valid the requester not granted last wins; after reset requester 0 has priority.
REQ-020 Handshake at (reqN_valid & reqN_ready) latches operands into mul_a/mul_b, records the grant owner, updates the round-robin pointer, and moves IDLE->ISSUE.
REQ-021 ISSUE lasts exactly one cycle with mul_start=1, then moves to BUSY; mul_start is 0 in every other state.
REQ-022 mul_a/mul_b hold stable from ISSUE until leaving RESP, and hold their last value in IDLE.
REQ-023 In BUSY, a watchdog counts cycles from 1; mul_done=1 captures mul_c into rsp_c, clears rsp_err, and moves to RESP.
REQ-024 If the watchdog reaches TIMEOUT without mul_done, the block moves to RESP with rsp_c=0 and rsp_err=1.
REQ-025 mul_done together with the timeout condition in the same cycle is treated as success.
REQ-026 mul_done outside BUSY is ignored with no state change; a pulse in ISSUE is also ignored.
REQ-027 In RESP, rspN_valid=1 only for the grant owner; rsp_c and rsp_err stay stable until (rspN_valid & rspN_ready), which returns the block to IDLE.
REQ-028 rspN_ready on the non-owner channel, and reqN_valid in any non-IDLE state, have no effect; reqN_ready=0 outside IDLE.
REQ-029 Latency: handshake in cycle T gives mul_start in T+1 and BUSY from T+2; mul_done in cycle D gives rspN_valid from D+1.
REQ-030 Back-to-back: a response consumed in cycle R returns the block to IDLE at R+1, where the next request is accepted.
REQ-031 The block performs no arithmetic on mul_c, which is passed through bit-exact.

Reset
REQ-032 Asserting rst forces, asynchronously: state=IDLE, mul_start=0, rsp0_valid=rsp1_valid=0, rsp_c=0, rsp_err=0, mul_a=mul_b=0, watchdog=0, round-robin pointer favouring requester 0.
REQ-033 Reset mid-operation abandons the in-flight request with no response; after reset release the first cycle is IDLE.

Verification
REQ-034 Single request: req0 with a=3, b=-5, core returns -15 four cycles after start -> rsp0_valid with rsp_c=-15 (2*WIDTH sign-extended) and rsp_err=0; req1 never sees a response.
REQ-035 Contention: req0 and req1 held valid continuously from reset -> grant order 0,1,0,1, and each response is routed to the matching rspN.
REQ-036 Timeout: TIMEOUT=8 with mul_done never asserted -> rsp_err=1 and rsp_c=0 in the 9th cycle after entering BUSY; mul_done coinciding with the 8th BUSY cycle -> success.
REQ-037 Backpressure: rsp0_ready held low for 20 cycles -> rsp_c stable, busy=1, req1_ready=0 throughout; release -> IDLE on the next cycle.
REQ-038 Reset in BUSY: rst pulsed mid-operation, then a late mul_done -> no response, busy=0, next request granted to req0.
REQ-039 Spurious pulses: mul_done asserted in IDLE and in ISSUE -> no state change and no rspN_valid.
